// File: rtl/eight_to_one_mux_if.sv
// Bundle of lane inputs, binary select and valid flag, plus the selected lane and its valid.
// The master side drives i/s/in_valid; the slave side (the mux) drives y/out_valid.
// WIDTH must match the WIDTH of the mux attached to the slave modport.
interface eight_to_one_mux_if #(
  parameter int WIDTH = 1
);
  logic [8*WIDTH-1:0] i;
  logic [2:0]         s;
  logic               in_valid;
  logic [WIDTH-1:0]   y;
  logic               out_valid;

  modport master (
    output i,
    output s,
    output in_valid,
    input  y,
    input  out_valid
  );

  modport slave (
    input  i,
    input  s,
    input  in_valid,
    output y,
    output out_valid
  );
endinterface

// File: rtl/eight_to_one_mux.sv
// 8:1 lane selector built as a fixed 2:1 tree (s[0], then s[1], then s[2]).
// Latency: 1 cycle with REG_OUT=1, combinational with REG_OUT=0.
// No backpressure: one word is taken every cycle; valid simply travels with the data.
module eight_to_one_mux #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  eight_to_one_mux_if.slave   bus
);

  logic [WIDTH-1:0] lane [8];
  logic [WIDTH-1:0] lvl1 [4];
  logic [WIDTH-1:0] lvl2 [2];
  logic [WIDTH-1:0] sel_dat;

  // Unpack the flat input bus into lanes; lane 0 sits at the LSBs.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane[k] = bus.i[k*WIDTH +: WIDTH];
    end
  end

  // Select tree: pairs (0,1)(2,3)(4,5)(6,7) on s[0], then s[1], then s[2].
  // Plain ternaries so an X/Z on s shows up as X on y instead of being masked.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lvl1[k] = bus.s[0] ? lane[2*k+1] : lane[2*k];
    end
    for (int k = 0; k < 2; k++) begin
      lvl2[k] = bus.s[1] ? lvl1[2*k+1] : lvl1[2*k];
    end
    sel_dat = bus.s[2] ? lvl2[1] : lvl2[0];
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Next-state: capture the selected lane every cycle; valid qualifies it downstream.
    always_comb begin
      y_d         = sel_dat;
      out_valid_d = bus.in_valid;
    end

    // Output register; reset clears data and valid immediately, dropping any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q         <= '0;
        out_valid_q <= 1'b0;
      end else begin
        y_q         <= y_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
  end else begin : g_comb
    assign bus.y         = sel_dat;
    assign bus.out_valid = bus.in_valid;
  end

endmodule

// File: tb/tb_eight_to_one_mux.sv
// Self-checking bench for eight_to_one_mux: combinational W1, registered W1 and registered W8 instances.
// Expected values come from fixed tables and a shift/mask lane model.
// Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
module tb_eight_to_one_mux;

  logic clk;
  logic rst_n;

  int tests_run;
  int tests_failed;

  eight_to_one_mux_if #(.WIDTH(1)) if_c ();
  eight_to_one_mux_if #(.WIDTH(1)) if_r ();
  eight_to_one_mux_if #(.WIDTH(8)) if_w ();

  eight_to_one_mux #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (.clk(clk), .rst_n(rst_n), .bus(if_c));
  eight_to_one_mux #(.WIDTH(1), .REG_OUT(1'b1)) u_reg  (.clk(clk), .rst_n(rst_n), .bus(if_r));
  eight_to_one_mux #(.WIDTH(8), .REG_OUT(1'b1)) u_wide (.clk(clk), .rst_n(rst_n), .bus(if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lane s of a flat bus holding eight w-bit lanes.
  function automatic logic [7:0] ref_lane(input logic [63:0] iv, input int s, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 8'((iv >> (s * w)) & mask);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    if_c.i = '0; if_c.s = '0; if_c.in_valid = 1'b0;
    if_r.i = 8'hFF; if_r.s = 3'd5; if_r.in_valid = 1'b1;
    if_w.i = {8{8'hAA}}; if_w.s = 3'd2; if_w.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (if_r.y !== 1'b0) begin tests_failed++; $display("FAIL reset_y_reg got=%b exp=0", if_r.y); end
    tests_run++;
    if (if_r.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_vld_reg got=%b exp=0", if_r.out_valid); end
    tests_run++;
    if (if_w.y !== 8'h00) begin tests_failed++; $display("FAIL reset_y_wide got=%h exp=00", if_w.y); end
    tests_run++;
    if (if_w.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_vld_wide got=%b exp=0", if_w.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    if_r.in_valid = 1'b0;
    if_w.in_valid = 1'b0;
  endtask

  task automatic test_comb_sweep();
    logic exp_y [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    if_c.i = 8'b11100101;
    for (int k = 0; k < 8; k++) begin
      if_c.s = 3'(k);
      if_c.in_valid = k[0];
      #1;
      tests_run++;
      if (if_c.y !== exp_y[k]) begin tests_failed++; $display("FAIL comb_sweep s=%0d got=%b exp=%b", k, if_c.y, exp_y[k]); end
      tests_run++;
      if (if_c.out_valid !== k[0]) begin tests_failed++; $display("FAIL comb_valid s=%0d got=%b exp=%b", k, if_c.out_valid, k[0]); end
      #9;
    end
  endtask

  task automatic test_reg_sweep();
    logic exp_y [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic prev;
    @(negedge clk);
    if_r.i = 8'b11100101;
    if_r.in_valid = 1'b1;
    if_r.s = 3'd0;
    @(posedge clk); #1;
    prev = exp_y[0];
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if_r.s = 3'(k);
      #1;
      tests_run++;
      if (if_r.y !== prev) begin tests_failed++; $display("FAIL reg_sweep_hold s=%0d got=%b exp=%b", k, if_r.y, prev); end
      @(posedge clk); #1;
      tests_run++;
      if (if_r.y !== exp_y[k]) begin tests_failed++; $display("FAIL reg_sweep s=%0d got=%b exp=%b", k, if_r.y, exp_y[k]); end
      prev = exp_y[k];
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    if_r.i = 8'hFF; if_r.s = 3'd4; if_r.in_valid = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (if_r.y !== 1'b1 || if_r.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL arst_pre y=%b vld=%b exp=1/1", if_r.y, if_r.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (if_r.y !== 1'b0 || if_r.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL arst_immediate y=%b vld=%b exp=0/0", if_r.y, if_r.out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (if_r.y !== 1'b0 || if_r.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL arst_hold y=%b vld=%b exp=0/0", if_r.y, if_r.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (if_r.y !== 1'b0 || if_r.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL arst_release y=%b vld=%b exp=0/0", if_r.y, if_r.out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (if_r.y !== 1'b1 || if_r.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL arst_first y=%b vld=%b exp=1/1", if_r.y, if_r.out_valid);
    end
  endtask

  task automatic test_valid_pipeline();
    @(negedge clk);
    if_r.in_valid = 1'b0; if_r.i = 8'h00; if_r.s = 3'd0;
    @(negedge clk);
    if_r.in_valid = 1'b1; if_r.i = 8'h08; if_r.s = 3'd3;
    @(posedge clk); #1;
    tests_run++;
    if (if_r.out_valid !== 1'b1 || if_r.y !== 1'b1) begin
      tests_failed++; $display("FAIL vld_pulse y=%b vld=%b exp=1/1", if_r.y, if_r.out_valid);
    end
    @(negedge clk);
    if_r.in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (if_r.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL vld_drop got=%b exp=0", if_r.out_valid);
    end
  endtask

  task automatic test_wide();
    int    sels [3]  = '{6, 0, 7};
    logic [7:0] exp [3] = '{8'h16, 8'h10, 8'h17};
    logic [63:0] iv;
    for (int k = 0; k < 8; k++) iv[k*8 +: 8] = 8'(8'h10 + k);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if_w.i = iv; if_w.s = 3'(sels[n]); if_w.in_valid = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (if_w.y !== exp[n] || if_w.out_valid !== 1'b1) begin
        tests_failed++; $display("FAIL wide s=%0d y=%h vld=%b exp=%h/1", sels[n], if_w.y, if_w.out_valid, exp[n]);
      end
    end
  endtask

  task automatic test_walking_one();
    int bad;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 8; s++) begin
        logic [7:0] iv;
        logic       exp;
        iv = 8'd1 << k;
        exp = (s == k);
        if_c.i = iv; if_c.s = 3'(s);
        #1;
        tests_run++;
        if (if_c.y !== exp) begin
          tests_failed++; bad++;
          if (bad < 10) $display("FAIL walk1 k=%0d s=%0d got=%b exp=%b", k, s, if_c.y, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_r;
    logic        exp_rv;
    logic [7:0]  exp_w;
    logic        exp_wv;
    logic [63:0] wv;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if_c.i = 8'($urandom); if_c.s = 3'($urandom_range(7)); if_c.in_valid = 1'($urandom);
      if_r.i = 8'($urandom); if_r.s = 3'($urandom_range(7)); if_r.in_valid = 1'($urandom);
      wv = {$urandom, $urandom};
      if_w.i = wv; if_w.s = 3'($urandom_range(7)); if_w.in_valid = 1'($urandom);
      exp_r  = ref_lane({56'd0, if_r.i}, int'(if_r.s), 1);
      exp_rv = if_r.in_valid;
      exp_w  = ref_lane(wv, int'(if_w.s), 8);
      exp_wv = if_w.in_valid;
      #1;
      tests_run++;
      if (if_c.y !== ref_lane({56'd0, if_c.i}, int'(if_c.s), 1)
          || if_c.out_valid !== if_c.in_valid) begin
        tests_failed++; $display("FAIL rnd_comb i=%h s=%0d y=%b vld=%b", if_c.i, if_c.s, if_c.y, if_c.out_valid);
      end
      @(posedge clk); #1;
      tests_run++;
      if (if_r.y !== exp_r[0] || if_r.out_valid !== exp_rv) begin
        tests_failed++; $display("FAIL rnd_reg y=%b vld=%b exp=%b/%b", if_r.y, if_r.out_valid, exp_r[0], exp_rv);
      end
      tests_run++;
      if (if_w.y !== exp_w || if_w.out_valid !== exp_wv) begin
        tests_failed++; $display("FAIL rnd_wide y=%h vld=%b exp=%h/%b", if_w.y, if_w.out_valid, exp_w, exp_wv);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_comb_sweep();
    test_reg_sweep();
    test_async_reset();
    test_valid_pipeline();
    test_wide();
    test_walking_one();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
